// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control-bundle types for the pipelined control unit.
// Bundles nest per stage so each pipeline register keeps only what it still needs.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] wb_sel;
  } wb_ctrl_t;

  typedef struct packed {
    logic     mem_read;
    logic     mem_write;
    wb_ctrl_t w;
  } mem_ctrl_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    mem_ctrl_t  m;
  } ex_ctrl_t;

  typedef struct packed {
    logic     branch;
    logic     jump;
    ex_ctrl_t ex;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  // Formats whose rs2 field is immediate bits must not trigger a load-use stall.
  function automatic logic uses_rs2(input logic [6:0] op);
    return !(op == OP_IALU || op == OP_LW || op == OP_JAL);
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage inputs and per-stage control outputs of the pipeline control unit.
interface pipe_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
);
  logic [6:0]         op_i;
  logic [REG_AW-1:0]  rs1_i;
  logic [REG_AW-1:0]  rs2_i;
  logic [REG_AW-1:0]  rd_i;
  logic               br_taken_i;
  logic               freeze_i;
  logic               pc_write_o;
  logic               ifid_write_o;
  logic               ifid_flush_o;
  logic               branch_o;
  logic               jump_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic               ex_alu_src_o;
  logic [REG_AW-1:0]  ex_rd_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic [REG_AW-1:0]  mem_rd_o;
  logic               wb_reg_write_o;
  logic [1:0]         wb_sel_o;
  logic [REG_AW-1:0]  wb_rd_o;

  modport master (
    output op_i, rs1_i, rs2_i, rd_i, br_taken_i, freeze_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, branch_o, jump_o,
    input  ex_alu_op_o, ex_alu_src_o, ex_rd_o,
    input  mem_read_o, mem_write_o, mem_rd_o,
    input  wb_reg_write_o, wb_sel_o, wb_rd_o
  );

  modport slave (
    input  op_i, rs1_i, rs2_i, rd_i, br_taken_i, freeze_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, branch_o, jump_o,
    output ex_alu_op_o, ex_alu_src_o, ex_rd_o,
    output mem_read_o, mem_write_o, mem_rd_o,
    output wb_reg_write_o, wb_sel_o, wb_rd_o
  );
endinterface

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Combinational RV32 opcode decoder producing the full control bundle for ID.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int JAL_EN = 0
) (
  input  logic [6:0]   op,
  output ctrl_bundle_t ctrl,
  output logic         use_rs2
);

  always_comb begin
    ctrl    = CTRL_NOP;
    use_rs2 = uses_rs2(op);
    case (op)
      OP_R: begin
        ctrl.ex.m.w.reg_write = 1'b1;
        ctrl.ex.alu_op        = ALUOP_R;
      end
      OP_IALU: begin
        ctrl.ex.m.w.reg_write = 1'b1;
        ctrl.ex.alu_src       = 1'b1;
        ctrl.ex.alu_op        = ALUOP_I;
      end
      OP_LW: begin
        ctrl.ex.m.w.reg_write = 1'b1;
        ctrl.ex.alu_src       = 1'b1;
        ctrl.ex.m.mem_read    = 1'b1;
        ctrl.ex.m.w.wb_sel    = WB_MEM;
        ctrl.ex.alu_op        = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.ex.alu_src    = 1'b1;
        ctrl.ex.m.mem_write = 1'b1;
        ctrl.ex.alu_op     = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch    = 1'b1;
        ctrl.ex.alu_op = ALUOP_SUB;
      end
      OP_JAL: begin
        if (JAL_EN != 0) begin
          ctrl.jump             = 1'b1;
          ctrl.ex.m.w.reg_write = 1'b1;
          ctrl.ex.m.w.wb_sel    = WB_PC4;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall with bubble insertion, branch/jump flush and global freeze.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2,
  parameter int JAL_EN  = 0
) (
  input logic        clk_i,
  input logic        rst_i,
  pipe_ctrl_if.slave bus
);

  ctrl_bundle_t      id_c;
  logic              id_use_rs2;
  ex_ctrl_t          ex_c;
  mem_ctrl_t         mem_c;
  wb_ctrl_t          wb_c;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              hazard;

  ctrl_decode #(.JAL_EN(JAL_EN)) u_decode (
    .op      (bus.op_i),
    .ctrl    (id_c),
    .use_rs2 (id_use_rs2)
  );

  // x0 never carries a real value, so a load into x0 cannot create a dependency.
  assign hazard = ex_c.m.mem_read && (ex_rd != '0) &&
                  ((ex_rd == bus.rs1_i) || (id_use_rs2 && (ex_rd == bus.rs2_i)));

  assign bus.pc_write_o   = !bus.freeze_i && !hazard;
  assign bus.ifid_write_o = !bus.freeze_i && !hazard;
  assign bus.ifid_flush_o = (bus.br_taken_i || id_c.jump) && !hazard && !bus.freeze_i;
  assign bus.branch_o     = id_c.branch;
  assign bus.jump_o       = id_c.jump;

  // Bubbles carry rd=0 so forwarding comparators downstream never hit them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_c   <= '0;
      mem_c  <= '0;
      wb_c   <= '0;
      ex_rd  <= '0;
      mem_rd <= '0;
      wb_rd  <= '0;
    end else if (!bus.freeze_i) begin
      ex_c   <= hazard ? CTRL_NOP.ex : id_c.ex;
      ex_rd  <= hazard ? '0 : bus.rd_i;
      mem_c  <= ex_c.m;
      mem_rd <= ex_rd;
      wb_c   <= mem_c.w;
      wb_rd  <= mem_rd;
    end
  end

  assign bus.ex_alu_op_o    = ALUOP_W'(ex_c.alu_op);
  assign bus.ex_alu_src_o   = ex_c.alu_src;
  assign bus.ex_rd_o        = ex_rd;
  assign bus.mem_read_o     = mem_c.mem_read;
  assign bus.mem_write_o    = mem_c.mem_write;
  assign bus.mem_rd_o       = mem_rd;
  assign bus.wb_reg_write_o = wb_c.reg_write;
  assign bus.wb_sel_o       = wb_c.wb_sel;
  assign bus.wb_rd_o        = wb_rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed table-driven bench for pipe_ctrl_unit with hand-computed expectations.
module tb_pipe_ctrl_unit;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic       pcw, ifw, fl, br, jmp;
    logic [1:0] ex_op;
    logic       ex_src;
    logic [4:0] ex_rd;
    logic       mr, mw;
    logic [4:0] mem_rd;
    logic       rw;
    logic [1:0] wsel;
    logic [4:0] wb_rd;
  } out_t;

  typedef struct {
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       bt, frz;
    out_t       exp;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipe_ctrl_if #(.REG_AW(5), .ALUOP_W(2)) bus ();

  pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(2), .JAL_EN(1)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic out_t o(bit pcw, bit ifw, bit fl, bit br, bit jmp,
                             int eop, bit esrc, int erd, bit mr, bit mw, int mrd,
                             bit rw, int ws, int wrd);
    out_t r;
    r = '{pcw, ifw, fl, br, jmp, 2'(eop), esrc, 5'(erd), mr, mw, 5'(mrd), rw, 2'(ws), 5'(wrd)};
    return r;
  endfunction

  function automatic vec_t v(logic [6:0] op, int rs1, int rs2, int rd, bit bt, bit frz, out_t e);
    vec_t r;
    r.op = op; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
    r.bt = bt; r.frz = frz; r.exp = e;
    return r;
  endfunction

  function automatic out_t sample();
    return {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.branch_o, bus.jump_o,
            bus.ex_alu_op_o, bus.ex_alu_src_o, bus.ex_rd_o,
            bus.mem_read_o, bus.mem_write_o, bus.mem_rd_o,
            bus.wb_reg_write_o, bus.wb_sel_o, bus.wb_rd_o};
  endfunction

  task automatic chk(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%07h want=%07h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked at the falling edge.
  task automatic apply(input string name, input vec_t x);
    @(posedge clk_i);
    #1;
    bus.op_i = x.op; bus.rs1_i = x.rs1; bus.rs2_i = x.rs2; bus.rd_i = x.rd;
    bus.br_taken_i = x.bt; bus.freeze_i = x.frz;
    @(negedge clk_i);
    chk(name, x.exp);
  endtask

  vec_t tbl[26];

  initial begin
    tbl[0]  = v(OP_R,    1, 2, 3, 0, 0, o(1,1,0,0,0, 0,0,0, 0,0,0, 0,0,0));
    tbl[1]  = v(7'd0,    0, 0, 0, 0, 0, o(1,1,0,0,0, 2,0,3, 0,0,0, 0,0,0));
    tbl[2]  = v(7'd0,    0, 0, 0, 0, 0, o(1,1,0,0,0, 0,0,0, 0,0,3, 0,0,0));
    tbl[3]  = v(OP_LW,   1, 0, 5, 0, 0, o(1,1,0,0,0, 0,0,0, 0,0,0, 1,0,3));
    tbl[4]  = v(OP_R,    5, 1, 6, 0, 0, o(0,0,0,0,0, 0,1,5, 0,0,0, 0,0,0));
    tbl[5]  = v(OP_R,    5, 1, 6, 0, 0, o(1,1,0,0,0, 0,0,0, 1,0,5, 0,0,0));
    tbl[6]  = v(OP_LW,   1, 0, 0, 0, 0, o(1,1,0,0,0, 2,0,6, 0,0,0, 1,1,5));
    tbl[7]  = v(OP_R,    0, 1, 6, 0, 0, o(1,1,0,0,0, 0,1,0, 0,0,6, 0,0,0));
    tbl[8]  = v(OP_LW,   1, 0, 5, 0, 0, o(1,1,0,0,0, 2,0,6, 1,0,0, 1,0,6));
    tbl[9]  = v(OP_IALU, 7, 5, 6, 0, 0, o(1,1,0,0,0, 0,1,5, 0,0,6, 1,1,0));
    tbl[10] = v(OP_BEQ,  1, 2, 8, 1, 0, o(1,1,1,1,0, 3,1,6, 1,0,5, 1,0,6));
    tbl[11] = v(7'd0,    0, 0, 0, 0, 0, o(1,1,0,0,0, 1,0,8, 0,0,6, 1,1,5));
    tbl[12] = v(OP_JAL,  0, 0, 1, 0, 0, o(1,1,1,0,1, 0,0,0, 0,0,8, 1,0,6));
    tbl[13] = v(7'd0,    0, 0, 0, 0, 0, o(1,1,0,0,0, 0,0,1, 0,0,0, 0,0,8));
    tbl[14] = v(OP_SW,   2, 3, 4, 0, 0, o(1,1,0,0,0, 0,0,0, 0,0,1, 0,0,0));
    tbl[15] = v(7'd0,    0, 0, 0, 0, 0, o(1,1,0,0,0, 0,1,4, 0,0,0, 1,2,1));
    tbl[16] = v(7'd0,    0, 0, 0, 0, 0, o(1,1,0,0,0, 0,0,0, 0,1,4, 0,0,0));
    tbl[17] = v(7'd0,    0, 0, 0, 0, 0, o(1,1,0,0,0, 0,0,0, 0,0,0, 0,0,4));
    tbl[18] = v(OP_LW,   2, 0, 9, 0, 0, o(1,1,0,0,0, 0,0,0, 0,0,0, 0,0,0));
    tbl[19] = v(OP_SW,   4, 9, 0, 0, 0, o(0,0,0,0,0, 0,1,9, 0,0,0, 0,0,0));
    tbl[20] = v(OP_SW,   4, 9, 0, 0, 0, o(1,1,0,0,0, 0,0,0, 1,0,9, 0,0,0));
    tbl[21] = v(7'd0,    0, 0, 0, 0, 0, o(1,1,0,0,0, 0,1,0, 0,0,0, 1,1,9));
    tbl[22] = v(OP_LW,   0, 0, 7, 0, 0, o(1,1,0,0,0, 0,0,0, 0,1,0, 0,0,0));
    tbl[23] = v(OP_BEQ,  7, 0, 0, 1, 0, o(0,0,0,1,0, 0,1,7, 0,0,0, 0,0,0));
    tbl[24] = v(OP_BEQ,  7, 0, 0, 1, 0, o(1,1,1,1,0, 0,0,0, 1,0,7, 0,0,0));
    tbl[25] = v(7'd0,    0, 0, 0, 0, 0, o(1,1,0,0,0, 1,0,0, 0,0,0, 1,1,7));

    bus.op_i = '0; bus.rs1_i = '0; bus.rs2_i = '0; bus.rd_i = '0;
    bus.br_taken_i = 1'b0; bus.freeze_i = 1'b0;
    #3;
    chk("reset", o(1,1,0,0,0, 0,0,0, 0,0,0, 0,0,0));
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 26; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Freeze for three cycles over a pending load-use, then exactly one bubble.
    apply("frz_lw",    v(OP_LW,  1, 0, 5, 0, 0, o(1,1,0,0,0, 0,0,0, 0,0,0, 0,0,0)));
    apply("frz_hold1", v(OP_R,   5, 1, 6, 0, 1, o(0,0,0,0,0, 0,1,5, 0,0,0, 0,0,0)));
    apply("frz_hold2", v(OP_R,   5, 1, 6, 0, 1, o(0,0,0,0,0, 0,1,5, 0,0,0, 0,0,0)));
    apply("frz_hold3", v(OP_R,   5, 1, 6, 0, 1, o(0,0,0,0,0, 0,1,5, 0,0,0, 0,0,0)));
    apply("frz_stall", v(OP_R,   5, 1, 6, 0, 0, o(0,0,0,0,0, 0,1,5, 0,0,0, 0,0,0)));
    apply("frz_bub",   v(OP_R,   5, 1, 6, 0, 0, o(1,1,0,0,0, 0,0,0, 1,0,5, 0,0,0)));
    apply("frz_after", v(7'd0,   0, 0, 0, 0, 0, o(1,1,0,0,0, 2,0,6, 0,0,0, 1,1,5)));
    apply("frz_br",    v(OP_BEQ, 1, 2, 0, 1, 1, o(0,0,0,1,0, 0,0,0, 0,0,6, 0,0,0)));
    apply("frz_rel",   v(7'd0,   0, 0, 0, 0, 0, o(1,1,0,0,0, 0,0,0, 0,0,6, 0,0,0)));

    // Asynchronous reset while a load sits in EX.
    apply("rst_pre0",  v(OP_LW,  1, 0, 5, 0, 0, o(1,1,0,0,0, 0,0,0, 0,0,0, 1,0,6)));
    apply("rst_pre1",  v(7'd0,   0, 0, 0, 0, 0, o(1,1,0,0,0, 0,1,5, 0,0,0, 0,0,0)));
    rst_i = 1'b1;
    #1;
    chk("rst_mid", o(1,1,0,0,0, 0,0,0, 0,0,0, 0,0,0));
    #1;
    rst_i = 1'b0;
    apply("rst_post",  v(7'd0,   0, 0, 0, 0, 0, o(1,1,0,0,0, 0,0,0, 0,0,0, 0,0,0)));
    apply("rst_post2", v(7'd0,   0, 0, 0, 0, 0, o(1,1,0,0,0, 0,0,0, 0,0,0, 0,0,0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
